// File: rtl/reset_sequencer.sv
// Sequences SoC reset release from PLL lock: synchronises lock, waits for a
// stable-lock window, then releases reset domains in order with a fixed gap.
module reset_sequencer #(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SW_HOLD     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked_async,
  input  logic              sw_reset_req,
  output logic [STAGES-1:0] stage_reset,
  output logic              all_released,
  output logic [2:0]        state,
  output logic [7:0]        relock_count
);

  localparam int unsigned MAX_AB  = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_CNT = (MAX_AB > SW_HOLD) ? MAX_AB : SW_HOLD;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD - 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  logic              sync1_q, locked_s_q;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAGES-1:0] stage_q, stage_d;
  logic              all_rel_q, all_rel_d;
  logic [7:0]        relock_q, relock_d;

  logic [STAGES-1:0] stage_shift;
  logic [7:0]        relock_inc;

  // Two-flop synchroniser for the raw PLL lock flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= pll_locked_async;
      locked_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_WAIT_LOCK;
      cnt_q     <= '0;
      stage_q   <= '1;
      all_rel_q <= 1'b0;
      relock_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      all_rel_q <= all_rel_d;
      relock_q  <= relock_d;
    end
  end

  // Releasing a stage shifts a zero in from bit 0; all-zero means the last one went
  assign stage_shift = stage_q << 1;
  assign relock_inc  = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    all_rel_d = all_rel_q;
    relock_d  = relock_q;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        stage_d   = '1;
        all_rel_d = 1'b0;
        if (locked_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end

      ST_STABLE: begin
        if (!locked_s_q) begin
          state_d   = ST_WAIT_LOCK;
          stage_d   = '1;
          all_rel_d = 1'b0;
          relock_d  = relock_inc;
        end else if (cnt_q == LOCK_LAST) begin
          cnt_d   = '0;
          stage_d = stage_shift;
          if (stage_shift == '0) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (!locked_s_q) begin
          state_d   = ST_WAIT_LOCK;
          stage_d   = '1;
          all_rel_d = 1'b0;
          relock_d  = relock_inc;
        end else if (sw_reset_req) begin
          state_d   = ST_HOLD;
          stage_d   = '1;
          all_rel_d = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          stage_d = stage_shift;
          if (stage_shift == '0) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s_q) begin
          state_d   = ST_WAIT_LOCK;
          stage_d   = '1;
          all_rel_d = 1'b0;
          relock_d  = relock_inc;
        end else if (sw_reset_req) begin
          state_d   = ST_HOLD;
          stage_d   = '1;
          all_rel_d = 1'b0;
          cnt_d     = '0;
        end
      end

      ST_HOLD: begin
        if (!locked_s_q) begin
          state_d   = ST_WAIT_LOCK;
          stage_d   = '1;
          all_rel_d = 1'b0;
          relock_d  = relock_inc;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_WAIT_LOCK;
        cnt_d     = '0;
        stage_d   = '1;
        all_rel_d = 1'b0;
      end
    endcase
  end

  assign stage_reset  = stage_q;
  assign all_released = all_rel_q;
  assign state        = 3'(state_q);
  assign relock_count = relock_q;

endmodule
